// File: rtl/shift_pkg.sv
// shift_pkg: op codes, FSM states and step-size constants shared by the shift sequencer.
package shift_pkg;
  typedef enum logic [1:0] {SH_SLL = 2'b00, SH_SRL = 2'b01, SH_ROTR = 2'b10, SH_SRA = 2'b11} op_e;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  localparam int STEP_W_DEF = 2;
  localparam int STEP_MAX = 2**STEP_W_DEF - 1;
endpackage

// File: rtl/shift_step.sv
// shift_step: combinational 0..2**STEP_W-1 bit shifter; op=ROTR rotates only with SHIFT_ROTATE_EN,
// otherwise it passes din through unchanged.
module shift_step import shift_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic [DATA_W-1:0] din,
  input  op_e               op,
  input  logic [STEP_W-1:0] step,
  output logic [DATA_W-1:0] dout
);
  logic [DATA_W-1:0] rot, sra;
  assign sra = $signed(din) >>> step;
`ifdef SHIFT_ROTATE_EN
  assign rot = (din >> step) | (din << (DATA_W - int'(step)));
`else
  assign rot = din;
`endif
  always_comb dout = op == SH_SLL ? din << step : op == SH_SRL ? din >> step : op == SH_SRA ? sra : rot;
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle SLL/SRL/SRA unit stepping up to 2**STEP_W-1 bits per edge.
// Define SHIFT_ROTATE_EN to make op=10 a rotate-right; otherwise op=10 passes din through.
module shift_sequencer import shift_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int AMT_W  = 5,
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [1:0]        op,
  input  logic [AMT_W-1:0]  amt,
  input  logic [DATA_W-1:0] din,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [DATA_W-1:0] result,
  output logic              busy
);
  localparam logic [AMT_W-1:0] SMAX = AMT_W'(2**STEP_W - 1);
`ifdef SHIFT_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif
  state_e            state_q, state_d;
  op_e               op_q, op_d, op_cur;
  logic [DATA_W-1:0] result_q, result_d, sh_in, sh_out;
  logic [AMT_W-1:0]  rem_q, rem_d, rem_cur, step_a;
  logic              accept, bypass;
  // The first step is taken on the accept edge itself, giving max(1, ceil(amt/STEP_MAX)) latency.
  always_comb begin
    accept   = state_q == IDLE && start_valid;
    op_cur   = accept ? op_e'(op) : op_q;
    rem_cur  = accept ? amt : rem_q;
    sh_in    = accept ? din : result_q;
    step_a   = rem_cur > SMAX ? SMAX : rem_cur;
    bypass   = op_cur == SH_ROTR && !ROT_EN;
    state_d  = state_q;
    result_d = result_q;
    rem_d    = rem_q;
    op_d     = op_q;
    if (accept || state_q == SHIFT) begin
      result_d = sh_out;
      op_d     = op_cur;
      rem_d    = bypass ? '0 : rem_cur - step_a;
      state_d  = rem_d == '0 ? DONE : SHIFT;
    end else if (state_q == DONE && result_ready) begin
      state_d  = IDLE;
    end
  end
  shift_step #(.DATA_W(DATA_W), .STEP_W(STEP_W)) u_step (
    .din  (sh_in),
    .op   (op_cur),
    .step (step_a[STEP_W-1:0]),
    .dout (sh_out)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      rem_q    <= '0;
      op_q     <= SH_SLL;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
    end
  end
  assign start_ready  = state_q == IDLE;
  assign result_valid = state_q == DONE;
  assign busy         = state_q != IDLE;
  assign result       = result_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: table-driven and random vectors through a result scoreboard, plus
// backpressure and mid-shift reset sequences.
module tb_shift_sequencer;
  logic        clk = 1'b0, rst_n = 1'b0, start_valid = 1'b0, result_ready = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [4:0]  amt = '0;
  logic [31:0] din = '0;
  logic        start_ready, result_valid, busy;
  logic [31:0] result;
  int          pass_n = 0, total_n = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  amt;
    logic [31:0] din;
    logic [31:0] exp;
    string       nm;
  } vec_t;
  vec_t tbl[10];

  shift_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .op(op), .amt(amt), .din(din), .result_valid(result_valid),
    .result_ready(result_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [4:0] a, input logic [31:0] d);
    logic signed [31:0] s;
    s = d;
    case (o)
      2'b00:   return d << a;
      2'b01:   return d >> a;
      2'b11:   return 32'(s >>> a);
`ifdef SHIFT_ROTATE_EN
      default: return (d >> a) | (d << (32 - int'(a)));
`else
      default: return d;
`endif
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic [4:0] a);
`ifndef SHIFT_ROTATE_EN
    if (o == 2'b10) return 1;
`endif
    return a == 0 ? 1 : (int'(a) + 2) / 3;
  endfunction

  // Accept one request, count edges to result_valid, compare against the scoreboard, then take it.
  task automatic issue(input logic [1:0] o, input logic [4:0] a, input logic [31:0] d,
                       input logic [31:0] e, input string nm);
    int lat;
    @(negedge clk);
    chk({nm, " start_ready"}, 32'(start_ready), 32'd1);
    start_valid = 1'b1; op = o; amt = a; din = d;
    @(posedge clk);
    exp_q.push_back(e);
    lat = 1;
    @(negedge clk);
    start_valid = 1'b0; op = 2'($urandom); amt = 5'($urandom); din = $urandom;
    while (!result_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, 32'(lat), 32'(model_lat(o, a)));
    chk({nm, " result"}, result, exp_q.pop_front());
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  initial begin
    tbl[0] = '{2'b00, 5'd5,  32'h0000_0001, 32'h0000_0020, "sll1x5"};
    tbl[1] = '{2'b11, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, "sra31"};
    tbl[2] = '{2'b01, 5'd31, 32'h8000_0000, 32'h0000_0001, "srl31"};
    tbl[3] = '{2'b00, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, "amt0"};
`ifdef SHIFT_ROTATE_EN
    tbl[4] = '{2'b10, 5'd4,  32'h0000_000F, 32'hF000_0000, "rotr"};
`else
    tbl[4] = '{2'b10, 5'd4,  32'h0000_000F, 32'h0000_000F, "rotr"};
`endif
    tbl[5] = '{2'b11, 5'd3,  32'h8000_0000, 32'hF000_0000, "sra3"};
    tbl[6] = '{2'b01, 5'd4,  32'hF000_0000, 32'h0F00_0000, "srl4"};
    tbl[7] = '{2'b00, 5'd12, 32'h1234_5678, 32'h4567_8000, "sll12"};
    tbl[8] = '{2'b11, 5'd30, 32'h7FFF_FFFF, 32'h0000_0001, "sra_pos"};
    tbl[9] = '{2'b11, 5'd1,  32'h8000_0001, 32'hC000_0000, "sra1"};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset start_ready", 32'(start_ready), 32'd1);
    chk("reset result_valid", 32'(result_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset result", result, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) issue(tbl[i].op, tbl[i].amt, tbl[i].din, tbl[i].exp, tbl[i].nm);

    for (int i = 0; i < 8; i++) begin
      logic [1:0]  o;
      logic [4:0]  a;
      logic [31:0] d;
      o = 2'($urandom); a = 5'($urandom); d = $urandom;
      issue(o, a, d, model(o, a, d), $sformatf("rand%0d", i));
    end

    // Backpressure: hold result for 4 cycles while a second request waits.
    @(negedge clk);
    start_valid = 1'b1; op = 2'b00; amt = 5'd5; din = 32'h1;
    @(posedge clk);
    @(negedge clk);
    chk("bp busy mid", 32'(busy), 32'd1);
    op = 2'b00; amt = 5'd0; din = 32'hCAFE_F00D;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("bp result_valid", 32'(result_valid), 32'd1);
      chk("bp result", result, 32'h20);
      chk("bp start_ready", 32'(start_ready), 32'd0);
      @(negedge clk);
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk("bp idle start_ready", 32'(start_ready), 32'd1);
    chk("bp idle result_valid", 32'(result_valid), 32'd0);
    @(negedge clk);
    start_valid = 1'b0;
    chk("bp next valid", 32'(result_valid), 32'd1);
    chk("bp next result", result, 32'hCAFE_F00D);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;

    // Reset for one edge in the middle of a long shift.
    @(negedge clk);
    start_valid = 1'b1; op = 2'b00; amt = 5'd20; din = 32'h1;
    @(negedge clk);
    start_valid = 1'b0;
    @(negedge clk);
    chk("rst busy before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst result_valid", 32'(result_valid), 32'd0);
    chk("rst result", result, 32'd0);
    chk("rst start_ready", 32'(start_ready), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    begin
      int seen = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (result_valid) seen++;
      end
      chk("rst no stale result", 32'(seen), 32'd0);
    end

    issue(2'b01, 5'd7, 32'h8000_0000, 32'h0100_0000, "after_rst");

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
